m5_sram_arbiter: RTL and testbench



---
 rtl/m5_sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_m5_sram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m5_sram_arbiter.sv
// Fixed-priority (loader > CPU > tape) sequencer for the shared 16-bit SRAM; ack in cycle N+1 (2N+1 for RMW writes).
// Define SRAM_ARB_RMW_EN for two bytes per word with read-modify-write byte stores.
module m5_sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        ldr_req_i,
  input  logic [21:0] ldr_addr_i,
  input  logic [7:0]  ldr_wdata_i,
  output logic        ldr_ack_o,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [21:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_wait_o,
  input  logic        tap_req_i,
  input  logic [21:0] tap_addr_i,
  output logic [7:0]  tap_rdata_o,
  output logic        tap_ack_o,
  output logic [20:0] sram_a_o,
  input  logic [15:0] sram_d_i,
  output logic [15:0] sram_d_o,
  output logic        sram_oe_o,
  output logic        sram_we_n_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_LDR, SRC_CPU, SRC_TAP} src_t;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  src_t        owner;
  logic        is_wr;
  logic        phase_end;
  logic        grant;
  src_t        g_src;
  logic        g_we;
  logic [21:0] g_addr;
  logic [7:0]  g_wdata;
  logic [20:0] g_word;
  logic [7:0]  rd_byte;

`ifdef SRAM_ARB_RMW_EN
  logic [7:0]  wbyte;
  logic        sel_hi;
  assign g_word  = g_addr[21:1];
  assign rd_byte = sel_hi ? sram_d_i[15:8] : sram_d_i[7:0];
`else
  logic        unused;
  assign g_word  = g_addr[20:0];
  assign rd_byte = sram_d_i[7:0];
  assign unused  = ^{g_addr[21], sram_d_i[15:8]};
`endif

  assign phase_end = (cnt == LAST);

  // Grant selection; acks are only ever high in ACK, so the ack mask never blocks a grant in IDLE.
  always_comb begin
    grant   = 1'b0;
    g_src   = SRC_NONE;
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    if (state == IDLE) begin
      if (ldr_req_i && !ldr_ack_o) begin
        grant = 1'b1; g_src = SRC_LDR; g_we = 1'b1; g_addr = ldr_addr_i; g_wdata = ldr_wdata_i;
      end else if (cpu_req_i && !cpu_ack_o) begin
        grant = 1'b1; g_src = SRC_CPU; g_we = cpu_we_i; g_addr = cpu_addr_i; g_wdata = cpu_wdata_i;
      end else if (tap_req_i && !tap_ack_o) begin
        grant = 1'b1; g_src = SRC_TAP; g_we = 1'b0; g_addr = tap_addr_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant) begin
          cnt_nxt = '0;
`ifdef SRAM_ARB_RMW_EN
          state_nxt = RD;
`else
          state_nxt = g_we ? WR : RD;
`endif
        end
      end
      RD: begin
        if (phase_end) begin
          cnt_nxt   = '0;
          state_nxt = is_wr ? WR : ACK;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WR: begin
        if (phase_end) begin
          cnt_nxt   = '0;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      owner       <= SRC_NONE;
      is_wr       <= 1'b0;
      sram_a_o    <= '0;
      sram_d_o    <= '0;
      cpu_rdata_o <= '0;
      tap_rdata_o <= '0;
`ifdef SRAM_ARB_RMW_EN
      wbyte       <= '0;
      sel_hi      <= 1'b0;
`endif
    end else begin
      if (grant) begin
        owner    <= g_src;
        is_wr    <= g_we;
        sram_a_o <= g_word;
`ifdef SRAM_ARB_RMW_EN
        wbyte    <= g_wdata;
        sel_hi   <= g_addr[0];
`else
        if (g_we) sram_d_o <= {8'h00, g_wdata};
`endif
      end
      if (state == RD && phase_end) begin
        if (!is_wr) begin
          if (owner == SRC_CPU) cpu_rdata_o <= rd_byte;
          if (owner == SRC_TAP) tap_rdata_o <= rd_byte;
        end
`ifdef SRAM_ARB_RMW_EN
        // Merge the new byte into the word just read; the WR phase then stores it back.
        if (is_wr) sram_d_o <= sel_hi ? {wbyte, sram_d_i[7:0]} : {sram_d_i[15:8], wbyte};
`endif
      end
    end
  end

  // First WR cycle is address setup; state resets asynchronously so WE releases at once.
  assign sram_we_n_o = !(state == WR && cnt != 4'd0);
  assign sram_oe_o   = (state == WR) || (state == ACK && is_wr);
  assign busy_o      = (state != IDLE);
  assign ldr_ack_o   = (state == ACK) && (owner == SRC_LDR);
  assign cpu_ack_o   = (state == ACK) && (owner == SRC_CPU);
  assign tap_ack_o   = (state == ACK) && (owner == SRC_TAP);
  assign cpu_wait_o  = cpu_req_i && !cpu_ack_o;

endmodule

// File: tb/tb_m5_sram_arbiter.sv
// Randomized bench for m5_sram_arbiter: byte-level memory model plus priority/latency schedule model.
// Covers both SRAM_ARB_RMW_EN builds; a second instance (N=4) checks a tape read stream.
module tb_m5_sram_arbiter;
  localparam int N  = 2;
  localparam int N4 = 4;
`ifdef SRAM_ARB_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ldr_req, ldr_ack;
  logic [21:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        cpu_req, cpu_we, cpu_ack, cpu_wait;
  logic [21:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        tap_req, tap_ack;
  logic [21:0] tap_addr;
  logic [7:0]  tap_rdata;
  logic [20:0] sram_a;
  logic [15:0] sram_din, sram_dout;
  logic        sram_oe, sram_we_n, busy;

  logic        tap4_req, tap4_ack;
  logic [21:0] tap4_addr;
  logic [7:0]  tap4_rdata, x_cpu_rdata;
  logic        x_ldr_ack, x_cpu_ack, x_cpu_wait, x_oe, x_we_n, x_busy;
  logic [20:0] sram4_a;
  logic [15:0] sram4_din, x_dout;

  logic [15:0] mem  [0:255];
  logic [15:0] mem4 [0:255];
  logic [15:0] exp_w[0:255];
  logic        poke_en;
  logic [7:0]  poke_a;
  logic [15:0] poke_v;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  m5_sram_arbiter #(.ACCESS_CYCLES(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .ldr_req_i(ldr_req), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata), .ldr_ack_o(ldr_ack),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_wait_o(cpu_wait),
    .tap_req_i(tap_req), .tap_addr_i(tap_addr), .tap_rdata_o(tap_rdata), .tap_ack_o(tap_ack),
    .sram_a_o(sram_a), .sram_d_i(sram_din), .sram_d_o(sram_dout),
    .sram_oe_o(sram_oe), .sram_we_n_o(sram_we_n), .busy_o(busy)
  );

  m5_sram_arbiter #(.ACCESS_CYCLES(N4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n),
    .ldr_req_i(1'b0), .ldr_addr_i(22'd0), .ldr_wdata_i(8'd0), .ldr_ack_o(x_ldr_ack),
    .cpu_req_i(1'b0), .cpu_we_i(1'b0), .cpu_addr_i(22'd0), .cpu_wdata_i(8'd0),
    .cpu_rdata_o(x_cpu_rdata), .cpu_ack_o(x_cpu_ack), .cpu_wait_o(x_cpu_wait),
    .tap_req_i(tap4_req), .tap_addr_i(tap4_addr), .tap_rdata_o(tap4_rdata), .tap_ack_o(tap4_ack),
    .sram_a_o(sram4_a), .sram_d_i(sram4_din), .sram_d_o(x_dout),
    .sram_oe_o(x_oe), .sram_we_n_o(x_we_n), .busy_o(x_busy)
  );

  // SRAM behaviour: asynchronous read, store while WE is low at the clock edge.
  assign sram_din  = mem[sram_a[7:0]];
  assign sram4_din = mem4[sram4_a[7:0]];
  always @(posedge clk) begin
    if (poke_en)         mem[poke_a] <= poke_v;
    else if (!sram_we_n) mem[sram_a[7:0]] <= sram_dout;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int dur(input bit we);
    return (we && RMW) ? 2 * N + 1 : N + 1;
  endfunction

  function automatic logic [7:0] word_of(input logic [7:0] b);
    return RMW ? {1'b0, b[7:1]} : b;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] b);
    logic [15:0] w;
    w = exp_w[word_of(b)];
    if (RMW && b[0]) return w[15:8];
    return w[7:0];
  endfunction

  function automatic logic [7:0] rd4(input logic [7:0] b);
    logic [15:0] w;
    w = mem4[word_of(b)];
    if (RMW && b[0]) return w[15:8];
    return w[7:0];
  endfunction

  task automatic model_write(input logic [7:0] b, input logic [7:0] d);
    logic [7:0] w;
    w = word_of(b);
    if (!RMW)     exp_w[w] = {8'h00, d};
    else if (b[0]) exp_w[w][15:8] = d;
    else          exp_w[w][7:0] = d;
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] v);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_a = a; poke_v = v; exp_w[a] = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Requests raised together; expected ack cycles follow priority order, each grant one cycle after the previous ack.
  task automatic run_batch(input bit l, input bit c, input bit t, input bit cwe, input bit hi,
                           input logic [7:0] la, input logic [7:0] ca, input logic [7:0] ta,
                           input logic [7:0] ld, input logic [7:0] cd);
    int ea[3];
    int tt, we_lows, n_wr;
    ea = '{-1, -1, -1};
    tt = 0;
    if (l) begin ea[0] = tt + dur(1'b1); tt = ea[0] + 1; end
    if (c) begin ea[1] = tt + dur(cwe);  tt = ea[1] + 1; end
    if (t) begin ea[2] = tt + dur(1'b0); tt = ea[2] + 1; end
    n_wr = int'(l) + int'(c && cwe);
    we_lows = 0;
    @(posedge clk); #1;
    ldr_req = l; ldr_addr = {hi, 13'd0, la}; ldr_wdata = ld;
    cpu_req = c; cpu_we = cwe; cpu_addr = {hi, 13'd0, ca}; cpu_wdata = cd;
    tap_req = t; tap_addr = {hi, 13'd0, ta};
    for (int k = 0; k <= tt; k++) begin
      @(negedge clk);
      chk("ldr_ack", ldr_ack, k == ea[0]);
      chk("cpu_ack", cpu_ack, k == ea[1]);
      chk("tap_ack", tap_ack, k == ea[2]);
      chk("cpu_wait", cpu_wait, cpu_req && (k != ea[1]));
      if (!sram_we_n) begin
        we_lows++;
        chk("oe_during_we", sram_oe, 1);
      end
      if (ldr_ack) begin
        model_write(la, ld);
        ldr_req = 1'b0;
      end
      if (cpu_ack) begin
        if (cwe) model_write(ca, cd);
        else     chk("cpu_rdata", cpu_rdata, model_read(ca));
        cpu_req = 1'b0;
      end
      if (tap_ack) begin
        chk("tap_rdata", tap_rdata, model_read(ta));
        tap_req = 1'b0;
      end
    end
    chk("all_acked", {ldr_req, cpu_req, tap_req}, 0);
    ldr_req = 1'b0; cpu_req = 1'b0; tap_req = 1'b0;
    chk("we_low_cycles", we_lows, n_wr * (N - 1));
    if (l)         chk("mem_ldr", mem[word_of(la)], exp_w[word_of(la)]);
    if (c && cwe)  chk("mem_cpu", mem[word_of(ca)], exp_w[word_of(ca)]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    int idx;
    bit l, c, t;
    reset_n = 1'b0;
    ldr_req = 0; ldr_addr = '0; ldr_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    tap_req = 0; tap_addr = '0;
    tap4_req = 0; tap4_addr = '0;
    poke_en = 0; poke_a = '0; poke_v = '0;

    for (int i = 0; i < 256; i++) begin
      mem4[i] = 16'($urandom);
      poke(8'(i), 16'($urandom));
    end

    @(negedge clk);
    chk("rst_sram_a", sram_a, 0);
    chk("rst_sram_d", sram_dout, 0);
    chk("rst_oe", sram_oe, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_acks", {ldr_ack, cpu_ack, tap_ack}, 0);
    chk("rst_rdata", {cpu_rdata, tap_rdata}, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_we_n", sram_we_n, 1);

    // CPU byte write, then read of an odd address in a known word.
    run_batch(0, 1, 0, 1, 0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h5A);
    poke(8'h08, 16'hBEEF);
    run_batch(0, 1, 0, 0, 0, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00);

    // All three at once.
    run_batch(1, 1, 0 | 1'b1, 0, 0, 8'h40, 8'h41, 8'h42, 8'hA5, 8'h00);
    run_batch(1, 1, 1, 1, 0, 8'h50, 8'h50, 8'h51, 8'h11, 8'h22);

    // Reset during the first WE-low cycle of a write.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 22'h30; cpu_wdata = 8'hC3;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (!sram_we_n) found = 1;
    end
    chk("rst_reach_we", found, 1);
    #1;
    reset_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("rst_mid_we_n", sram_we_n, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ack", cpu_ack, 0);
    chk("rst_mid_oe", sram_oe, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ack", cpu_ack, 0);
    chk("post_rst_mem", mem[word_of(8'h30)], exp_w[word_of(8'h30)]);

    // Random batches.
    for (int i = 0; i < 40; i++) begin
      l = 1'($urandom); c = 1'($urandom); t = 1'($urandom);
      if (!(l || c || t)) t = 1'b1;
      run_batch(l, c, t, 1'($urandom), (!RMW) && 1'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // N=4 tape stream: requester keeps req high and advances the address on each ack.
    @(posedge clk); #1;
    tap4_req = 1'b1; tap4_addr = 22'h20; idx = 0;
    for (int k = 0; k < 8 * (N4 + 2) + 4 && idx < 8; k++) begin
      @(negedge clk);
      chk("tap4_ack", tap4_ack, k == (N4 + 1) + idx * (N4 + 2));
      if (tap4_ack) begin
        chk("tap4_rdata", tap4_rdata, rd4(tap4_addr[7:0]));
        idx++;
        if (idx == 8) tap4_req = 1'b0;
        else          tap4_addr = tap4_addr + 22'd1;
      end
    end
    chk("tap4_count", idx, 8);
    tap4_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
